// File: rtl/map_pkg.sv
// Shared definitions for the scrolling map generator: tile codes, FSM states,
// LFSR taps and the difficulty-to-threshold mapping.
package map_pkg;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_LOW   = 2'd1;
    localparam logic [1:0] TILE_HIGH  = 2'd2;
    localparam logic [1:0] TILE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [4:0] THR_D0 = 5'd4;
    localparam logic [4:0] THR_D1 = 5'd6;
    localparam logic [4:0] THR_D2 = 5'd8;
    localparam logic [4:0] THR_D3 = 5'd10;

    function automatic logic [4:0] diff_threshold(input logic [1:0] difficulty);
        case (difficulty)
            2'd0:    return THR_D0;
            2'd1:    return THR_D1;
            2'd2:    return THR_D2;
            default: return THR_D3;
        endcase
    endfunction

    // Galois right-shift step; the generator decides tiles from this post-step value.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/map_generator_lfsr16.sv
// 16-bit Galois LFSR that advances once per step strobe; only rst_n reloads the seed.
module lfsr16
    import map_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= SEED;
        else if (step)
            value <= lfsr_step(value);
    end

endmodule

// File: rtl/map_generator.sv
// Scrolling obstacle-map producer: game FSM, obstacle spacing counter and the
// tile shift register that feeds the physics engine.
module map_generator
    import map_pkg::*;
#(
    parameter int          NUM_TILES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MIN_GAP   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   run,
    input  logic                   is_dead,
    input  logic [1:0]             difficulty,
    output logic [2*NUM_TILES-1:0] map_tiles,
    output logic                   tile_valid,
    output logic [15:0]            scroll_count,
    output logic [1:0]             state
);

    localparam logic [7:0] GAP_MAX = 8'(MIN_GAP);

    state_t      cur_state;
    logic [7:0]  gap_cnt;
    logic [7:0]  gap_next;
    logic [1:0]  new_tile;
    logic [15:0] lfsr_value;
    logic [15:0] lfsr_post;
    logic        accept;

    assign accept    = (cur_state == PLAY) && tick && run && !is_dead;
    assign lfsr_post = lfsr_step(lfsr_value);
    assign state     = cur_state;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (accept),
        .value (lfsr_value)
    );

    // Spacing rule first: an obstacle is only possible once the gap has refilled.
    always_comb begin
        new_tile = TILE_EMPTY;
        gap_next = gap_cnt;
        if (gap_cnt < GAP_MAX) begin
            gap_next = gap_cnt + 8'd1;
        end else if ({1'b0, lfsr_post[3:0]} < diff_threshold(difficulty)) begin
            new_tile = lfsr_post[4] ? TILE_HIGH : TILE_LOW;
            gap_next = 8'd0;
        end else begin
            gap_next = GAP_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= IDLE;
            map_tiles    <= '0;
            tile_valid   <= 1'b0;
            scroll_count <= 16'd0;
            gap_cnt      <= GAP_MAX;
        end else begin
            tile_valid <= 1'b0;
            case (cur_state)
                IDLE: begin
                    map_tiles <= '0;
                    gap_cnt   <= GAP_MAX;
                    if (run) begin
                        cur_state    <= PLAY;
                        scroll_count <= 16'd0;
                    end
                end
                PLAY: begin
                    if (is_dead) begin
                        cur_state <= DEAD;
                    end else if (!run) begin
                        cur_state <= IDLE;
                        map_tiles <= '0;
                    end else if (tick) begin
                        map_tiles  <= {map_tiles[2*NUM_TILES-3:0], new_tile};
                        gap_cnt    <= gap_next;
                        tile_valid <= 1'b1;
                        if (scroll_count != 16'hFFFF)
                            scroll_count <= scroll_count + 16'd1;
                    end
                end
                DEAD: begin
                    if (!run) begin
                        cur_state <= IDLE;
                        map_tiles <= '0;
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_generator.sv
// Scoreboard bench for map_generator: directed ticks push expected map/count,
// a negedge monitor pops and compares on every tile_valid pulse.
module tb_map_generator;

    typedef struct packed {
        logic [15:0] map;
        logic [15:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic        is_dead = 1'b0;
    logic [1:0]  difficulty = 2'd0;
    logic [15:0] map_tiles;
    logic        tile_valid;
    logic [15:0] scroll_count;
    logic [1:0]  state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        long_phase = 1'b0;
    int          mon_gap = 2;
    int          obstacles = 0;
    int          free_slots = 0;

    logic [15:0] m_lfsr;
    int          m_gap;
    logic [15:0] m_map;
    logic [15:0] m_cnt;

    map_generator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .run          (run),
        .is_dead      (is_dead),
        .difficulty   (difficulty),
        .map_tiles    (map_tiles),
        .tile_valid   (tile_valid),
        .scroll_count (scroll_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Push the expected response, then hold tick high across one rising edge.
    task automatic apply_stimulus(input logic [15:0] map, input logic [15:0] count);
        exp_t e;
        e.map   = map;
        e.count = count;
        exp_q.push_back(e);
        tick = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Independent reference of the tile rules for the long random run.
    task automatic model_tick();
        logic [15:0] l;
        logic [1:0]  t;
        int          thr;
        l   = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        thr = 4 + 2 * int'(difficulty);
        t   = 2'd0;
        if (m_gap < 2) begin
            m_gap++;
        end else if (int'(l[3:0]) < thr) begin
            t     = l[4] ? 2'd2 : 2'd1;
            m_gap = 0;
        end
        m_lfsr = l;
        m_map  = {m_map[13:0], t};
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    always @(negedge clk) begin
        if (rst_n && tile_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got map %h count %h, expected no pulse at %0t",
                         map_tiles, scroll_count, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("map_tiles", map_tiles, e.map);
                check_output("scroll_count", scroll_count, e.count);
            end
            if (long_phase) begin
                if (mon_gap < 2) begin
                    mon_gap++;
                end else begin
                    free_slots++;
                    if (map_tiles[1:0] != 2'd0) begin
                        obstacles++;
                        mon_gap = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2;
        check_output("reset_map", map_tiles, 16'h0000);
        check_output("reset_valid", {15'd0, tile_valid}, 16'd0);
        check_output("reset_count", scroll_count, 16'h0000);
        check_output("reset_state", {14'd0, state}, 16'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("idle_state", {14'd0, state}, 16'd0);

        // run rises together with a tick: the tick must not be accepted
        run  = 1'b1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        check_output("play_state", {14'd0, state}, 16'd1);
        check_output("play_map", map_tiles, 16'h0000);

        apply_stimulus(16'h0002, 16'd1);
        apply_stimulus(16'h0008, 16'd2);
        apply_stimulus(16'h0020, 16'd3);
        apply_stimulus(16'h0080, 16'd4);
        apply_stimulus(16'h0200, 16'd5);
        apply_stimulus(16'h0802, 16'd6);
        tick = 1'b0;
        @(posedge clk); #1;

        // death wins over tick in the same cycle
        is_dead = 1'b1;
        tick    = 1'b1;
        @(posedge clk); #1;
        is_dead = 1'b0;
        check_output("dead_state", {14'd0, state}, 16'd2);
        check_output("dead_map", map_tiles, 16'h0802);
        repeat (3) @(posedge clk);
        #1;
        tick = 1'b0;
        check_output("dead_hold_map", map_tiles, 16'h0802);
        check_output("dead_hold_count", scroll_count, 16'd6);
        check_output("dead_hold_state", {14'd0, state}, 16'd2);

        run = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_output("idle_again_state", {14'd0, state}, 16'd0);
        check_output("idle_again_map", map_tiles, 16'h0000);

        // restart: LFSR continues from where the last game stopped
        run = 1'b1;
        @(posedge clk); #1;
        check_output("restart_state", {14'd0, state}, 16'd1);
        check_output("restart_count", scroll_count, 16'd0);
        apply_stimulus(16'h0000, 16'd1);
        apply_stimulus(16'h0000, 16'd2);
        apply_stimulus(16'h0001, 16'd3);
        tick = 1'b0;
        @(posedge clk); @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_map", map_tiles, 16'h0000);
        check_output("async_count", scroll_count, 16'h0000);
        check_output("async_state", {14'd0, state}, 16'd0);
        check_output("queue_drained_1", 16'(exp_q.size()), 16'd0);

        @(posedge clk); #1;
        rst_n      = 1'b1;
        difficulty = 2'd3;
        run        = 1'b1;
        @(posedge clk); #1;
        m_lfsr     = 16'hACE1;
        m_gap      = 2;
        m_map      = 16'h0000;
        m_cnt      = 16'h0000;
        long_phase = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            model_tick();
            apply_stimulus(m_map, m_cnt);
        end
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        long_phase = 1'b0;
        check_output("saturated_count", scroll_count, 16'hFFFF);
        check_output("queue_drained_2", 16'(exp_q.size()), 16'd0);
        check_output("obstacle_ratio_ok",
                     {15'd0, (obstacles * 100 >= free_slots * 45) && (obstacles * 100 <= free_slots * 80)},
                     16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/map_generator.md
# map_generator

Scrolling obstacle-map producer for Unicorn Explosion. It is the writer side of the 16-bit `map_tiles` bus that the physics engine reads. On each scroll strobe it shifts the 8-tile map one position toward the player at bits [15:14]. A new tile, chosen pseudo-randomly under spacing and difficulty rules, enters at bits [1:0]. It freezes when the physics engine reports death and clears for a new game.

## Interface
Parameters:
- `NUM_TILES`, 8: tiles in the map; bus width = 2*NUM_TILES.
- `LFSR_SEED`, 16'hACE1: non-zero LFSR reset value.
- `MIN_GAP`, 2: minimum empty tiles forced after every obstacle.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tick`  in  1: one-cycle scroll strobe from the speed divider.
- `run`  in  1: game enable, level-sensitive.
- `is_dead`  in  1: death flag from physics engine.
- `difficulty`  in  2: obstacle density select.
- `map_tiles`  out  16: tile map; [15:14] is the player tile.
- `tile_valid`  out  1: one-cycle pulse, map just shifted.
- `scroll_count`  out  16: tiles scrolled this game.
- `state`  out  2: current FSM state, for debug and UI.

## Operation
- Tile codes: 0 empty, 1 low block (must jump), 2 high block (must not jump), 3 reserved and never generated.
- FSM states are IDLE=0, PLAY=1, DEAD=2.
- IDLE:
  - map_tiles=0 and gap_cnt=MIN_GAP.
  - When `run`=1: go to PLAY and clear scroll_count.
- PLAY, on `tick`:
  - Shift: map_tiles <= {map_tiles[13:0], new_tile}.
  - Advance the LFSR once.
  - Increment scroll_count, saturating at 16'hFFFF.
  - Pulse tile_valid.
- LFSR: 16-bit Galois, taps mask 16'hB400, right shift. If lsb=1: next=(cur>>1)^16'hB400; otherwise next=cur>>1. The new tile is decided from the post-step value L.
- New tile:
  - If gap_cnt < MIN_GAP: tile=0 and gap_cnt++.
  - Else if L[3:0] < thr: tile = L[4] ? 2 : 1, and gap_cnt=0.
  - Else: tile=0, and gap_cnt++ saturating at MIN_GAP.
  - thr = 4, 6, 8, 10 for difficulty 0..3.
- PLAY, `is_dead`=1: go to DEAD. No shift happens that cycle, even if `tick`=1.
- PLAY, `run`=0: go to IDLE. Map clears on the next edge.
- DEAD:
  - map_tiles, scroll_count and LFSR are held, and `tick` is ignored.
  - `run`=0 goes to IDLE.
- Priority in PLAY: `is_dead` > `!run` > `tick`.
- The LFSR is reset only by rst_n, never on game restart.

## Timing
- Reset values:
  - map_tiles=0, tile_valid=0, scroll_count=0.
  - state=IDLE, LFSR=LFSR_SEED, gap_cnt=MIN_GAP.
- Latency: `tick` sampled at edge N makes the new map and the tile_valid pulse visible after edge N. This is one cycle of latency.
- tile_valid is high for exactly one cycle per accepted tick.
- A new obstacle reaches the player tile NUM_TILES-1 = 7 accepted ticks after insertion.
- `run` rising in IDLE gives PLAY on the next edge. A tick in that same cycle is not accepted.
- Back-to-back ticks on consecutive cycles are each accepted.
- All outputs are registered, with no combinational input-to-output path.
- Async reset mid-game returns everything to reset values immediately.

## Structure
- Package `map_pkg` holds:
  - Tile code constants TILE_EMPTY, TILE_LOW, TILE_HIGH, TILE_RSVD.
  - The state enum for IDLE/PLAY/DEAD.
  - LFSR_TAPS=16'hB400.
  - The difficulty threshold constants.
- Sub-module `lfsr16`: has clk, rst_n, step, seed parameter and 16-bit value out.
- The FSM, gap counter and shift register are in the top level.

## Test plan
- Reset then run=1, difficulty=0, one tick:
  - LFSR goes to 16'hE270 (L[3:0]=0, L[4]=1).
  - map_tiles=16'h0002, tile_valid pulses once, scroll_count=1.
- Two more ticks after that: gap forces empties, giving map_tiles=16'h0008, then 16'h0020.
- is_dead=1 and tick=1 in the same cycle during PLAY:
  - No shift, state=DEAD, map held.
  - Further ticks ignored.
  - run=0 gives IDLE with map_tiles=0.
- 10,000 ticks at difficulty 3:
  - No tile code 3 ever appears.
  - Every obstacle is followed by at least 2 zero tiles.
  - Obstacle ratio is within about 10/16 of the non-forced slots.
- rst_n asserted mid-PLAY with the map non-zero: all outputs are zero and state=IDLE immediately, without waiting for a clock edge.
- Preload scroll_count near 16'hFFFF, or run 65,540 ticks: scroll_count saturates at 16'hFFFF and shifting continues.
